// File: rtl/seq_alu.sv
// Multi-cycle ALU for the EX stage: logic/shift/add/compare in one cycle,
// signed MUL (shift-add) and DIV (restoring) iterate one bit per cycle.
module seq_alu #(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_cnt,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero_flag,
   output logic             neg_flag,
   output logic             div_zero,
   output logic             bad_op
);

   localparam int CW = SHW + 1;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_NOT = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SRL = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_DIV = 4'b1001;
   localparam logic [3:0] OP_SRA = 4'b1010;
   localparam logic [3:0] OP_XOR = 4'b1011;

   typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

   state_t             r_state, w_stateNext;
   logic [CW-1:0]      r_count;
   logic [WIDTH-1:0]   r_hi, r_lo, r_mcand, r_opA;
   logic               r_negQ, r_negR, r_dz;
   logic [WIDTH-1:0]   r_result, r_resultHi;
   logic               r_divZero, r_badOp;

   logic [WIDTH-1:0]   w_aluRes;
   logic               w_badOp;
   logic [WIDTH-1:0]   w_magA, w_magB;
   logic [WIDTH-1:0]   w_mulAdd;
   logic [WIDTH:0]     w_mulSum;
   logic [2*WIDTH-1:0] w_mulProd, w_mulFinal;
   logic [WIDTH:0]     w_divShift, w_divTrial;
   logic               w_divGe;
   logic [WIDTH-1:0]   w_divRem, w_divQuo, w_quoFinal, w_remFinal;

   always_comb begin
      w_aluRes = '0;
      w_badOp  = 1'b0;
      case (alu_cnt)
         OP_ADD: w_aluRes = input1 + input2;
         OP_SUB: w_aluRes = input1 - input2;
         OP_NOT: w_aluRes = ~input1;
         OP_SLL: w_aluRes = input1 << shamt;
         OP_SRL: w_aluRes = input1 >> shamt;
         OP_AND: w_aluRes = input1 & input2;
         OP_OR:  w_aluRes = input1 | input2;
         OP_SLT: w_aluRes = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
         OP_SRA: w_aluRes = $signed(input1) >>> shamt;
         OP_XOR: w_aluRes = input1 ^ input2;
         OP_MUL, OP_DIV: w_aluRes = '0;
         default: w_badOp = 1'b1;
      endcase
   end

   // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
   assign w_magA = input1[WIDTH-1] ? -input1 : input1;
   assign w_magB = input2[WIDTH-1] ? -input2 : input2;

   assign w_mulAdd   = r_lo[0] ? r_mcand : '0;
   assign w_mulSum   = {1'b0, r_hi} + {1'b0, w_mulAdd};
   assign w_mulProd  = {w_mulSum, r_lo[WIDTH-1:1]};
   assign w_mulFinal = r_negQ ? -w_mulProd : w_mulProd;

   // Partial remainder stays below the divisor, so bit WIDTH of the trial is a clean borrow.
   assign w_divShift = {r_hi, r_lo[WIDTH-1]};
   assign w_divTrial = w_divShift - {1'b0, r_mcand};
   assign w_divGe    = ~w_divTrial[WIDTH];
   assign w_divRem   = w_divGe ? w_divTrial[WIDTH-1:0] : w_divShift[WIDTH-1:0];
   assign w_divQuo   = {r_lo[WIDTH-2:0], w_divGe};
   assign w_quoFinal = r_negQ ? -w_divQuo : w_divQuo;
   assign w_remFinal = r_negR ? -w_divRem : w_divRem;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               if (alu_cnt == OP_MUL)      w_stateNext = MUL_RUN;
               else if (alu_cnt == OP_DIV) w_stateNext = DIV_RUN;
               else                        w_stateNext = DONE;
            end
         end
         MUL_RUN, DIV_RUN: if (r_count == CW'(1)) w_stateNext = DONE;
         DONE:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count    <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_mcand    <= '0;
         r_opA      <= '0;
         r_negQ     <= 1'b0;
         r_negR     <= 1'b0;
         r_dz       <= 1'b0;
         r_result   <= '0;
         r_resultHi <= '0;
         r_divZero  <= 1'b0;
         r_badOp    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_count <= CW'(WIDTH);
                  r_hi    <= '0;
                  if (alu_cnt == OP_MUL) begin
                     r_lo    <= w_magB;
                     r_mcand <= w_magA;
                     r_negQ  <= input1[WIDTH-1] ^ input2[WIDTH-1];
                  end else if (alu_cnt == OP_DIV) begin
                     r_lo    <= w_magA;
                     r_mcand <= w_magB;
                     r_negQ  <= input1[WIDTH-1] ^ input2[WIDTH-1];
                     r_negR  <= input1[WIDTH-1];
                     r_dz    <= (input2 == '0);
                     r_opA   <= input1;
                  end else begin
                     r_result   <= w_aluRes;
                     r_resultHi <= '0;
                     r_divZero  <= 1'b0;
                     r_badOp    <= w_badOp;
                  end
               end
            end
            MUL_RUN: begin
               r_hi    <= w_mulProd[2*WIDTH-1:WIDTH];
               r_lo    <= w_mulProd[WIDTH-1:0];
               r_count <= r_count - 1'b1;
               if (r_count == CW'(1)) begin
                  r_result   <= w_mulFinal[WIDTH-1:0];
                  r_resultHi <= w_mulFinal[2*WIDTH-1:WIDTH];
                  r_divZero  <= 1'b0;
                  r_badOp    <= 1'b0;
               end
            end
            DIV_RUN: begin
               r_hi    <= w_divRem;
               r_lo    <= w_divQuo;
               r_count <= r_count - 1'b1;
               if (r_count == CW'(1)) begin
                  r_badOp <= 1'b0;
                  if (r_dz) begin
                     r_result   <= '1;
                     r_resultHi <= r_opA;
                     r_divZero  <= 1'b1;
                  end else begin
                     r_result   <= w_quoFinal;
                     r_resultHi <= w_remFinal;
                     r_divZero  <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign result    = r_result;
   assign result_hi = r_resultHi;
   assign zero_flag = (r_result == '0);
   assign neg_flag  = r_result[WIDTH-1];
   assign div_zero  = r_divZero;
   assign bad_op    = r_badOp;

endmodule

// File: tb/tb_seq_alu.sv
// Directed plus light random bench for seq_alu; expected results come from a
// behavioural model and are queued at issue, popped on out_valid.
module tb_seq_alu;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         zf;
      logic         nf;
      logic         dz;
      logic         bo;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   alu_cnt;
   logic [W-1:0] input1, input2;
   logic [4:0]   shamt;
   logic         out_valid;
   logic [W-1:0] result, result_hi;
   logic         zero_flag, neg_flag, div_zero, bad_op;

   int   testCount = 0;
   int   failCount = 0;
   int   cycleCnt  = 0;
   int   acceptCnt = 0;
   exp_t sbQ[$];

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_cnt(alu_cnt), .input1(input1), .input2(input2), .shamt(shamt),
      .out_valid(out_valid), .result(result), .result_hi(result_hi),
      .zero_flag(zero_flag), .neg_flag(neg_flag), .div_zero(div_zero), .bad_op(bad_op)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   function automatic exp_t modelOp(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [4:0] sh);
      exp_t   e;
      longint sa, sb, p, q, rm;
      e  = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd0:  e.res = a + b;
         4'd1:  e.res = a - b;
         4'd2:  e.res = ~a;
         4'd3:  e.res = a << sh;
         4'd4:  e.res = a >> sh;
         4'd5:  e.res = a & b;
         4'd6:  e.res = a | b;
         4'd7:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd8: begin
            p     = sa * sb;
            e.res = p[31:0];
            e.hi  = p[63:32];
         end
         4'd9: begin
            if (b == 0) begin
               e.res = '1;
               e.hi  = a;
               e.dz  = 1'b1;
            end else begin
               q     = sa / sb;
               rm    = sa % sb;
               e.res = q[31:0];
               e.hi  = rm[31:0];
            end
         end
         4'd10: e.res = $signed(a) >>> sh;
         4'd11: e.res = a ^ b;
         default: e.bo = 1'b1;
      endcase
      e.zf = (e.res == 0);
      e.nf = e.res[W-1];
      return e;
   endfunction

   task automatic checkValue(input string name, input logic [W-1:0] obs, input logic [W-1:0] expv);
      testCount++;
      assert (obs === expv) else begin
         failCount++;
         $error("[TB] FAIL %s: got %h, expected %h", name, obs, expv);
      end
   endtask

   // Drives one request for a single cycle and queues its expected outcome.
   task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [4:0] sh);
      @(negedge clk);
      alu_cnt  = op;
      input1   = a;
      input2   = b;
      shamt    = sh;
      in_valid = 1'b1;
      sbQ.push_back(modelOp(op, a, b, sh));
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      acceptCnt = cycleCnt;
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      checkValue({tag, " sb_pending"}, (sbQ.size() != 0), 1);
      if (sbQ.size() != 0) begin
         e = sbQ.pop_front();
         checkValue({tag, " result"},    result,    e.res);
         checkValue({tag, " result_hi"}, result_hi, e.hi);
         checkValue({tag, " zero_flag"}, zero_flag, e.zf);
         checkValue({tag, " neg_flag"},  neg_flag,  e.nf);
         checkValue({tag, " div_zero"},  div_zero,  e.dz);
         checkValue({tag, " bad_op"},    bad_op,    e.bo);
      end
   endtask

   task automatic waitResult(input string tag, input int expLat);
      int waited = 0;
      bit seen   = 1'b0;
      bit busyOk = 1'b1;
      while (!seen && waited < 200) begin
         @(negedge clk);
         waited++;
         if (in_ready !== 1'b0) busyOk = 1'b0;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checkValue({tag, " out_valid_seen"}, seen, 1);
      if (seen) begin
         checkValue({tag, " latency"}, cycleCnt - acceptCnt + 1, expLat);
         checkValue({tag, " in_ready_low_while_busy"}, busyOk, 1);
         checkOutput(tag);
         @(negedge clk);
         checkValue({tag, " out_valid_pulse_ends"}, out_valid, 0);
         checkValue({tag, " in_ready_back"}, in_ready, 1);
      end
   endtask

   task automatic runOp(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh);
      applyStimulus(op, a, b, sh);
      waitResult(tag, (op == 4'd8 || op == 4'd9) ? W + 1 : 1);
   endtask

   initial begin
      bit           extra;
      logic [3:0]   rop;
      logic [W-1:0] ra, rb;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      alu_cnt  = '0;
      input1   = '0;
      input2   = '0;
      shamt    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkValue("reset in_ready",  in_ready,  1);
      checkValue("reset out_valid", out_valid, 0);
      checkValue("reset result",    result,    0);
      checkValue("reset result_hi", result_hi, 0);
      checkValue("reset zero_flag", zero_flag, 1);
      checkValue("reset neg_flag",  neg_flag,  0);
      checkValue("reset div_zero",  div_zero,  0);
      checkValue("reset bad_op",    bad_op,    0);
      rst_n = 1'b1;

      runOp("add_ovf",  4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);
      runOp("mul_7x-3", 4'd8, 32'd7, 32'hFFFF_FFFD, 5'd0);
      runOp("div_-7/2", 4'd9, 32'hFFFF_FFF9, 32'd2, 5'd0);
      runOp("div_min/-1", 4'd9, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
      runOp("div_5/0",  4'd9, 32'd5, 32'd0, 5'd0);
      runOp("sub_3-3",  4'd1, 32'd3, 32'd3, 5'd0);

      // ADD request while a MUL is running must be dropped.
      applyStimulus(4'd8, 32'h0001_2345, 32'hFFFF_FF00, 5'd0);
      repeat (9) @(negedge clk);
      alu_cnt  = 4'd0;
      input1   = 32'd1;
      input2   = 32'd2;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      waitResult("mul_busy", W + 1);
      extra = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid === 1'b1) extra = 1'b1;
      end
      checkValue("busy no_second_out_valid", extra, 0);

      runOp("sra_min_4", 4'd10, 32'h8000_0000, 32'd0, 5'd4);
      runOp("srl_min_4", 4'd4,  32'h8000_0000, 32'd0, 5'd4);
      runOp("bad_1100",  4'd12, 32'h1234_5678, 32'd9, 5'd0);
      runOp("sll_sh0",   4'd3,  32'hA5A5_0F0F, 32'd0, 5'd0);
      runOp("slt_neg",   4'd7,  32'hFFFF_FFFF, 32'd1, 5'd0);
      runOp("xor",       4'd11, 32'hF0F0_1234, 32'h0FF0_4321, 5'd0);
      runOp("mul_min_min", 4'd8, 32'h8000_0000, 32'h8000_0000, 5'd0);
      runOp("div_-9/-4", 4'd9, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 5'd0);
      runOp("bad_1111",  4'd15, 32'd1, 32'd1, 5'd0);

      for (int i = 0; i < 12; i++) begin
         rop = 4'($urandom_range(0, 11));
         ra  = $urandom;
         rb  = (i % 4 == 3) ? 32'($urandom_range(0, 20)) : $urandom;
         runOp("random", rop, ra, rb, 5'($urandom_range(0, 31)));
      end

      // Reset in the middle of a DIV: nothing may come out afterwards.
      applyStimulus(4'd9, 32'd1000, 32'd7, 5'd0);
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkValue("midreset in_ready",  in_ready,  1);
      checkValue("midreset out_valid", out_valid, 0);
      checkValue("midreset result",    result,    0);
      checkValue("midreset zero_flag", zero_flag, 1);
      sbQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      extra = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid === 1'b1) extra = 1'b1;
      end
      checkValue("midreset no_out_valid", extra, 0);
      runOp("after_reset_and", 4'd5, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
      runOp("after_reset_or",  4'd6, 32'h0000_00F0, 32'h0000_0F00, 5'd0);
      runOp("after_reset_not", 4'd2, 32'h0000_FFFF, 32'd0, 5'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
